store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the MEM stage and the data `ram`. It accepts stores from the MEM stage into a FIFO of DEPTH word-entries and retires one entry per cycle onto the ram write port. Loads read the ram combinationally and are byte-merged with all pending buffered stores to the same word, so the pipeline always observes program-order memory contents. It asserts a stall only when a store arrives, the buffer is full and no entry retires that cycle.

## Interface
- DEPTH, 4, number of buffered store entries; power of two, ≥2
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clock
- store_enable  in  1  MEM stage issues a store this cycle
- store_address  in  32  byte address; bits [1:0] ignored, word address = [31:2]
- store_select  in  4  byte lanes to write, bit3 = [31:24]
- store_data  in  32  lane-aligned store data
- load_enable  in  1  MEM stage issues a load this cycle
- load_address  in  32  byte address; word address = [31:2]
- load_data  out  32  merged word, combinational; 0 when load_enable low
- drain_hold  in  1  blocks retirement this cycle
- stall_request  out  1  store cannot be accepted; MEM stage must hold it
- empty  out  1  no pending stores
- ram_chip_enable  out  1  tied high while reset is high
- ram_read_enable  out  1  = load_enable
- ram_read_address  out  32  = load_address
- ram_read_data  in  32  combinational ram read result
- ram_write_enable  out  1  head entry retiring this cycle
- ram_write_address / ram_write_select / ram_write_data  out  32/4/32  head entry fields; 0 when ram_write_enable low

## Operation
- Storage: DEPTH entries {word address [31:2], select[3:0], data[31:0]}; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits, range 0..DEPTH.
- pop = reset high && !empty && !drain_hold. ram_write_* driven combinationally from head entry when pop.
- push = reset high && store_enable && (count < DEPTH || pop). Full buffer with simultaneous pop accepts the store (count unchanged, both pointers advance).
- stall_request = reset high && store_enable && count == DEPTH && !pop. A stalled store is not enqueued; MEM stage re-presents identical values next cycle.
- store_select == 0 with store_enable: enqueued as a no-op entry, retires with ram_write_select = 0.
- Load merge: start from ram_read_data; walk entries oldest (head) to newest; for every valid entry whose word address equals load_address[31:2], overwrite each lane whose select bit is set. Newest store wins per byte. The head entry retiring this cycle is included (ram write lands at negedge, after the combinational read).
- Store and load in the same cycle: load does not see the store being enqueued that cycle.
- empty = (count == 0). No coalescing of stores to the same word.

## Timing
- Reset (reset low at posedge): count, head, tail ← 0; entry contents don't care. Pending stores discarded, never written to ram. While reset low: stall_request 0, ram_write_enable 0, ram_chip_enable 0, load_data 0, empty reflects count.
- Store latency: enqueued at posedge N; earliest retirement is cycle N+1 (ram write at negedge of that cycle) if buffer was empty and drain_hold low.
- Load latency: 0 cycles, combinational, including forwarding.
- Throughput: one push and one pop per cycle.
- drain_hold asserted indefinitely: buffer fills after DEPTH stores; stall_request high on every further store until hold drops.

## Test plan
- Reset then single store addr 0x100 sel 4'b1111 data 0xDEADBEEF -> next cycle ram_write_enable 1, addr 0x100, data 0xDEADBEEF; empty 1 after.
- drain_hold 1, stores to 0x0,0x4,0x8,0xC, then 0x10 -> stall_request 1 on 5th; release hold -> 5th accepted same cycle as first pop, retirement order 0x0..0x10.
- ram word 0x11223344 at 0x20; hold, store sel 4'b0001 data 0xAA then sel 4'b0010 data 0xBB00 at 0x20; load 0x20 -> load_data 0x1122BBAA.
- Two stores to 0x40 sel 4'b1111 data 0x1 then 0x2, load 0x40 -> 0x00000002 (newest wins).
- Full buffer with drain_hold 0 and store_enable each cycle -> stall_request stays 0, one write per cycle, wrap-around preserves order over 3×DEPTH stores.
- Three pending stores, reset low one cycle -> no ram writes after, empty 1, subsequent load returns raw ram data.

Source files
------------

// File: rtl/store_buffer_if.sv
// MEM-stage store/load port and data-ram port of the posted-write store buffer.
// The master side is the pipeline plus ram; the slave side is the buffer itself.
interface store_buffer_if;
    logic        store_enable;
    logic [31:0] store_address;
    logic [3:0]  store_select;
    logic [31:0] store_data;
    logic        load_enable;
    logic [31:0] load_address;
    logic [31:0] load_data;
    logic        drain_hold;
    logic        stall_request;
    logic        empty;
    logic        ram_chip_enable;
    logic        ram_read_enable;
    logic [31:0] ram_read_address;
    logic [31:0] ram_read_data;
    logic        ram_write_enable;
    logic [31:0] ram_write_address;
    logic [3:0]  ram_write_select;
    logic [31:0] ram_write_data;

    modport master (
        output store_enable, store_address, store_select, store_data,
        output load_enable, load_address, drain_hold, ram_read_data,
        input  load_data, stall_request, empty,
        input  ram_chip_enable, ram_read_enable, ram_read_address,
        input  ram_write_enable, ram_write_address, ram_write_select, ram_write_data
    );

    modport slave (
        input  store_enable, store_address, store_select, store_data,
        input  load_enable, load_address, drain_hold, ram_read_data,
        output load_data, stall_request, empty,
        output ram_chip_enable, ram_read_enable, ram_read_address,
        output ram_write_enable, ram_write_address, ram_write_select, ram_write_data
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and the data ram: retires one store per
// cycle and forwards pending store bytes into combinational loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    store_buffer_if.slave bus
);
    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [29:0]      word_r   [DEPTH];
    logic [3:0]       select_r [DEPTH];
    logic [31:0]      data_r   [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   count_r;

    logic             pop_s;
    logic             push_s;
    logic             stall_s;
    logic [PTR_W-1:0] slot_s;
    logic             hit_s;
    logic [31:0]      merged_s;
    logic             unused_s;

    // Store address byte offset is irrelevant: entries are word-granular.
    assign unused_s = ^bus.store_address[1:0];

    // Retire, accept and stall decisions for the current cycle.
    always_comb begin
        pop_s   = 1'b0;
        push_s  = 1'b0;
        stall_s = 1'b0;
        if (reset) begin
            pop_s   = (count_r != COUNT_ZERO) && !bus.drain_hold;
            push_s  = bus.store_enable && ((count_r < FULL_COUNT) || pop_s);
            stall_s = bus.store_enable && (count_r == FULL_COUNT) && !pop_s;
        end else begin
            pop_s   = 1'b0;
            push_s  = 1'b0;
            stall_s = 1'b0;
        end
    end

    // Head entry drives the ram write port only while it retires.
    always_comb begin
        bus.ram_write_enable  = 1'b0;
        bus.ram_write_address = 32'h0000_0000;
        bus.ram_write_select  = 4'h0;
        bus.ram_write_data    = 32'h0000_0000;
        if (pop_s) begin
            bus.ram_write_enable  = 1'b1;
            bus.ram_write_address = {word_r[head_r], 2'b00};
            bus.ram_write_select  = select_r[head_r];
            bus.ram_write_data    = data_r[head_r];
        end else begin
            bus.ram_write_enable  = 1'b0;
            bus.ram_write_address = 32'h0000_0000;
            bus.ram_write_select  = 4'h0;
            bus.ram_write_data    = 32'h0000_0000;
        end
    end

    // Forward pending bytes oldest to newest so the newest store wins per lane;
    // the retiring head is included because the ram write lands after this read.
    always_comb begin
        merged_s = bus.ram_read_data;
        slot_s   = PTR_ZERO;
        hit_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s = head_r + PTR_W'(i);
            hit_s  = ({1'b0, PTR_W'(i)} < count_r) &&
                     (word_r[slot_s] == bus.load_address[31:2]);
            for (int b = 0; b < 4; b++) begin
                merged_s[8*b +: 8] = (hit_s && select_r[slot_s][b]) ?
                                     data_r[slot_s][8*b +: 8] : merged_s[8*b +: 8];
            end
        end
    end

    assign bus.load_data        = (reset && bus.load_enable) ? merged_s : 32'h0000_0000;
    assign bus.stall_request    = stall_s;
    assign bus.empty            = (count_r == COUNT_ZERO);
    assign bus.ram_chip_enable  = reset;
    assign bus.ram_read_enable  = bus.load_enable;
    assign bus.ram_read_address = bus.load_address;

    // Pointer and occupancy update; reset discards every pending store.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload; contents of unoccupied slots are never observed.
    always_ff @(posedge clock) begin
        if (push_s) begin
            word_r[tail_r]   <= bus.store_address[31:2];
            select_r[tail_r] <= bus.store_select;
            data_r[tail_r]   <= bus.store_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic,
// compared each cycle against a queue-based program-order memory model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [29:0] word;
        logic [3:0]  sel;
        logic [31:0] data;
    } entry_t;

    logic clock = 1'b0;
    logic reset;

    store_buffer_if bus ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    logic [31:0] ram_mem [256];
    logic [31:0] ref_ram [256];
    entry_t      pend [$];
    int          n_cmp;
    int          n_err;
    logic        exp_stall_last;
    logic        obs_stall_last;
    logic [31:0] obs_load_last;

    assign bus.ram_read_data = ram_mem[bus.ram_read_address[9:2]];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [3:0] sel,
                                                input logic [31:0] data);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, let the ram take its write.
    task automatic cycle(input logic rst, input logic se, input logic [31:0] sa,
                         input logic [3:0] ss, input logic [31:0] sd, input logic le,
                         input logic [31:0] la, input logic hold);
        int          size;
        logic        exp_pop;
        logic        exp_push;
        logic        exp_stall;
        logic [31:0] exp_load;
        @(posedge clock);
        #1;
        reset             = rst;
        bus.store_enable  = se;
        bus.store_address = sa;
        bus.store_select  = ss;
        bus.store_data    = sd;
        bus.load_enable   = le;
        bus.load_address  = la;
        bus.drain_hold    = hold;
        #3;
        size      = pend.size();
        exp_pop   = rst && (size > 0) && !hold;
        exp_push  = rst && se && ((size < DEPTH) || exp_pop);
        exp_stall = rst && se && (size == DEPTH) && !exp_pop;
        exp_load  = 32'h0;
        if (rst && le) begin
            exp_load = ref_ram[la[9:2]];
            foreach (pend[k]) begin
                if (pend[k].word == la[31:2]) exp_load = merge_lanes(exp_load, pend[k].sel, pend[k].data);
            end
        end
        check("stall_request", 32'(bus.stall_request), 32'(exp_stall));
        check("empty", 32'(bus.empty), 32'(size == 0));
        check("load_data", bus.load_data, exp_load);
        check("ram_chip_enable", 32'(bus.ram_chip_enable), 32'(rst));
        check("ram_read_enable", 32'(bus.ram_read_enable), 32'(le));
        check("ram_read_address", bus.ram_read_address, la);
        check("ram_write_enable", 32'(bus.ram_write_enable), 32'(exp_pop));
        if (exp_pop) begin
            check("ram_write_address", bus.ram_write_address, {pend[0].word, 2'b00});
            check("ram_write_select", 32'(bus.ram_write_select), 32'(pend[0].sel));
            check("ram_write_data", bus.ram_write_data, pend[0].data);
        end else begin
            check("ram_write_address_idle", bus.ram_write_address, 32'h0);
            check("ram_write_select_idle", 32'(bus.ram_write_select), 32'h0);
            check("ram_write_data_idle", bus.ram_write_data, 32'h0);
        end
        exp_stall_last = exp_stall;
        obs_stall_last = bus.stall_request;
        obs_load_last  = bus.load_data;
        @(negedge clock);
        if (bus.ram_write_enable) begin
            ram_mem[bus.ram_write_address[9:2]] = merge_lanes(ram_mem[bus.ram_write_address[9:2]],
                                                              bus.ram_write_select, bus.ram_write_data);
        end
        if (!rst) begin
            pend.delete();
        end else begin
            if (exp_pop) begin
                ref_ram[pend[0].word[7:0]] = merge_lanes(ref_ram[pend[0].word[7:0]], pend[0].sel, pend[0].data);
                void'(pend.pop_front());
            end
            if (exp_push) pend.push_back('{word: sa[31:2], sel: ss, data: sd});
        end
    endtask

    task automatic idle(input logic hold);
        cycle(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, hold);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic hold);
        cycle(1'b1, 1'b1, a, s, d, 1'b0, 32'h0, hold);
    endtask

    task automatic load(input logic [31:0] a, input logic hold);
        cycle(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, a, hold);
    endtask

    initial begin
        logic        r_rst;
        logic        r_hold;
        logic        r_se;
        logic [31:0] r_sa;
        logic [3:0]  r_ss;
        logic [31:0] r_sd;
        logic        r_le;
        logic [31:0] r_la;
        n_cmp          = 0;
        n_err          = 0;
        exp_stall_last = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom;
            ref_ram[i] = ram_mem[i];
        end
        ram_mem[8] = 32'h1122_3344;
        ref_ram[8] = 32'h1122_3344;
        reset             = 1'b0;
        bus.store_enable  = 1'b0;
        bus.store_address = 32'h0;
        bus.store_select  = 4'h0;
        bus.store_data    = 32'h0;
        bus.load_enable   = 1'b0;
        bus.load_address  = 32'h0;
        bus.drain_hold    = 1'b0;

        cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h4, 4'hF, 32'h5, 1'b1, 32'h20, 1'b0);

        store(32'h100, 4'hF, 32'hDEAD_BEEF, 1'b0);
        idle(1'b0);
        idle(1'b0);

        store(32'h0, 4'hF, 32'hA000_0000, 1'b1);
        store(32'h4, 4'hF, 32'hA000_0004, 1'b1);
        store(32'h8, 4'hF, 32'hA000_0008, 1'b1);
        store(32'hC, 4'hF, 32'hA000_000C, 1'b1);
        store(32'h10, 4'hF, 32'hA000_0010, 1'b1);
        check("plan_full_stall", 32'(obs_stall_last), 32'h1);
        store(32'h10, 4'hF, 32'hA000_0010, 1'b0);
        check("plan_release_accept", 32'(obs_stall_last), 32'h0);
        for (int i = 0; i < 6; i++) idle(1'b0);

        store(32'h20, 4'b0001, 32'h0000_00AA, 1'b1);
        store(32'h20, 4'b0010, 32'h0000_BB00, 1'b1);
        load(32'h20, 1'b1);
        check("plan_byte_merge", obs_load_last, 32'h1122_BBAA);
        for (int i = 0; i < 3; i++) idle(1'b0);

        store(32'h40, 4'hF, 32'h0000_0001, 1'b1);
        store(32'h40, 4'hF, 32'h0000_0002, 1'b1);
        load(32'h42, 1'b1);
        check("plan_newest_wins", obs_load_last, 32'h0000_0002);
        for (int i = 0; i < 3; i++) idle(1'b0);

        for (int i = 0; i < DEPTH; i++) store(32'h80 + 32'(4 * i), 4'hF, $urandom, 1'b1);
        for (int i = 0; i < 3 * DEPTH; i++) store(32'h90 + 32'(4 * i), 4'(i), $urandom, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b0);

        store(32'h60, 4'hF, 32'h1111_1111, 1'b1);
        store(32'h64, 4'hF, 32'h2222_2222, 1'b1);
        store(32'h60, 4'hF, 32'h3333_3333, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h60, 1'b1);
        idle(1'b0);
        load(32'h60, 1'b0);
        load(32'h64, 1'b0);

        r_se = 1'b0;
        r_sa = 32'h0;
        r_ss = 4'h0;
        r_sd = 32'h0;
        for (int n = 0; n < 400; n++) begin
            r_rst  = ($urandom_range(0, 59) != 0);
            r_hold = ($urandom_range(0, 2) == 0);
            if (!exp_stall_last) begin
                r_se = ($urandom_range(0, 2) != 0);
                r_sa = {22'd0, 4'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                r_ss = 4'($urandom);
                r_sd = $urandom;
            end
            r_le = ($urandom_range(0, 1) != 0);
            r_la = {22'd0, 4'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            cycle(r_rst, r_se, r_sa, r_ss, r_sd, r_le, r_la, r_hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
